// File: rtl/sram_word_ctrl_pkg.sv
// Shared types and constants for the 32-bit word to x16 SRAM bridge.
// State encodings, SRAM geometry and the per-state memory-control decode.
package sram_word_ctrl_pkg;

  localparam int unsigned MEM_DATA_WIDTH = 16;
  localparam int unsigned MEM_ADDR_WIDTH = 16;
  localparam int unsigned BUS_WIDTH      = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    RD_WAIT,
    WR_LO,
    WR_HI
  } state_t;

  typedef struct packed {
    logic cs;
    logic rwbar;
    logic lsb;
    logic drive;
  } mem_ctl_t;

  // Memory-side pins as they must look while the FSM sits in state s.
  function automatic mem_ctl_t state_ctl(input state_t s);
    mem_ctl_t c;
    c = '{cs: 1'b0, rwbar: 1'b1, lsb: 1'b0, drive: 1'b0};
    case (s)
      RD_LO:   c = '{cs: 1'b1, rwbar: 1'b1, lsb: 1'b0, drive: 1'b0};
      RD_HI:   c = '{cs: 1'b1, rwbar: 1'b1, lsb: 1'b1, drive: 1'b0};
      WR_LO:   c = '{cs: 1'b1, rwbar: 1'b0, lsb: 1'b0, drive: 1'b1};
      WR_HI:   c = '{cs: 1'b1, rwbar: 1'b0, lsb: 1'b1, drive: 1'b1};
      default: c = '{cs: 1'b0, rwbar: 1'b1, lsb: 1'b0, drive: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sram_tri_buf.sv
// Tristate driver for the shared SRAM databus plus the sampled low half-word.
module sram_tri_buf
  import sram_word_ctrl_pkg::*;
#(
  parameter int unsigned BUS_W    = BUS_WIDTH,
  parameter int unsigned SAMPLE_W = MEM_DATA_WIDTH
) (
  input  logic                oe,
  input  logic [BUS_W-1:0]    dout,
  output logic [SAMPLE_W-1:0] din,
  inout  wire  [BUS_W-1:0]    bus
);

  assign bus = oe ? dout : 'z;
  assign din = bus[SAMPLE_W-1:0];

endmodule

// File: rtl/sram_word_ctrl.sv
// Splits 32-bit word requests into two x16 synchronous-SRAM half-word accesses.
// Optional half-word write strobes are enabled with `define SRAM_CTRL_HWSTRB_EN.
module sram_word_ctrl
  import sram_word_ctrl_pkg::*;
#(
  parameter int unsigned WADDR_WIDTH = MEM_ADDR_WIDTH - 1,
  parameter int unsigned MEM_WIDTH   = MEM_DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WADDR_WIDTH-1:0] req_addr,
  input  logic [BUS_WIDTH-1:0]   req_wdata,
`ifdef SRAM_CTRL_HWSTRB_EN
  input  logic [1:0]             req_hwe,
`endif
  output logic                   rsp_valid,
  output logic [BUS_WIDTH-1:0]   rsp_rdata,
  output logic                   mem_cs,
  output logic                   mem_rwbar,
  output logic [WADDR_WIDTH:0]   mem_adbus,
  inout  wire  [BUS_WIDTH-1:0]   mem_databus
);

  state_t                 state, next_state;
  logic [WADDR_WIDTH-1:0] addr_q, cur_addr;
  logic [BUS_WIDTH-1:0]   wdata_q, cur_wdata;
  logic                   wr_hi_q;
  logic [1:0]             hwe_eff;
  logic                   accept;
  logic                   rsp_next;
  mem_ctl_t               ctl_next;
  logic [WADDR_WIDTH:0]   adbus_next;
  logic                   bus_oe;
  logic [BUS_WIDTH-1:0]   bus_dout, dout_next;
  logic [MEM_WIDTH-1:0]   bus_din, rd_lo_q;

`ifdef SRAM_CTRL_HWSTRB_EN
  assign hwe_eff = req_hwe;
`else
  assign hwe_eff = 2'b11;
`endif

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    next_state = state;
    rsp_next   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (!req_we)          next_state = RD_LO;
          else if (hwe_eff[0])  next_state = WR_LO;
          else if (hwe_eff[1])  next_state = WR_HI;
          else                  rsp_next   = 1'b1;
        end
      end
      RD_LO:   next_state = RD_HI;
      RD_HI:   next_state = RD_WAIT;
      RD_WAIT: begin
        next_state = IDLE;
        rsp_next   = 1'b1;
      end
      WR_LO: begin
        if (wr_hi_q) begin
          next_state = WR_HI;
        end else begin
          next_state = IDLE;
          rsp_next   = 1'b1;
        end
      end
      WR_HI: begin
        next_state = IDLE;
        rsp_next   = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

  // Pins are registered from the next state, so they line up with the state
  // they belong to; in IDLE the request fields are used before they are latched.
  always_comb begin
    ctl_next   = state_ctl(next_state);
    cur_addr   = (state == IDLE) ? req_addr  : addr_q;
    cur_wdata  = (state == IDLE) ? req_wdata : wdata_q;
    adbus_next = ctl_next.cs ? {cur_addr, ctl_next.lsb} : mem_adbus;
    dout_next  = '0;
    if (ctl_next.drive) begin
      dout_next = {{(BUS_WIDTH-MEM_WIDTH){1'b0}},
                   ctl_next.lsb ? cur_wdata[BUS_WIDTH-1 -: MEM_WIDTH]
                                : cur_wdata[MEM_WIDTH-1:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_hi_q   <= 1'b0;
      mem_cs    <= 1'b0;
      mem_rwbar <= 1'b1;
      mem_adbus <= '0;
      bus_oe    <= 1'b0;
      bus_dout  <= '0;
      rd_lo_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= next_state;
      mem_cs    <= ctl_next.cs;
      mem_rwbar <= ctl_next.rwbar;
      mem_adbus <= adbus_next;
      bus_oe    <= ctl_next.drive;
      bus_dout  <= dout_next;
      rsp_valid <= rsp_next;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wr_hi_q <= hwe_eff[1];
      end
      // SRAM data lags its address by one cycle: low half arrives in RD_HI,
      // high half in RD_WAIT.
      if (state == RD_HI)   rd_lo_q   <= bus_din;
      if (state == RD_WAIT) rsp_rdata <= {bus_din, rd_lo_q};
    end
  end

  sram_tri_buf #(
    .BUS_W    (BUS_WIDTH),
    .SAMPLE_W (MEM_WIDTH)
  ) u_tri_buf (
    .oe   (bus_oe),
    .dout (bus_dout),
    .din  (bus_din),
    .bus  (mem_databus)
  );

  a_drive_only_in_write: assert property (@(posedge clk) disable iff (rst)
    bus_oe == (mem_cs && !mem_rwbar));
  a_rsp_when_idle: assert property (@(posedge clk) disable iff (rst)
    rsp_valid |-> req_ready);

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Directed bench for sram_word_ctrl with a one-cycle registered-read x16 SRAM model.
module tb_sram_word_ctrl;

  localparam int unsigned ADW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [ADW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic [1:0]    req_hwe = 2'b11;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          mem_cs;
  logic          mem_rwbar;
  logic [ADW:0]  mem_adbus;
  wire  [31:0]   mem_databus;

  int checks = 0;
  int errors = 0;

  sram_word_ctrl #(
    .WADDR_WIDTH (ADW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
`ifdef SRAM_CTRL_HWSTRB_EN
    .req_hwe     (req_hwe),
`endif
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .mem_cs      (mem_cs),
    .mem_rwbar   (mem_rwbar),
    .mem_adbus   (mem_adbus),
    .mem_databus (mem_databus)
  );

  always #5 clk = ~clk;

  // SRAM model: registered read, write captured at posedge.
  logic [15:0] sram [64];
  logic [15:0] sram_q = '0;
  logic        sram_oe = 1'b0;
  logic        probe_en = 1'b0;
  logic [31:0] probe_val = '0;

  assign mem_databus = sram_oe  ? {16'h0, sram_q} : 'z;
  assign mem_databus = probe_en ? probe_val       : 'z;

  always @(posedge clk) begin
    sram_oe <= mem_cs && mem_rwbar;
    if (mem_cs && mem_rwbar)  sram_q <= sram[mem_adbus];
    if (mem_cs && !mem_rwbar) sram[mem_adbus] <= mem_databus[15:0];
  end

  int contention = 0;
  int xz_cycles  = 0;
  int cs_cycles  = 0;
  always @(negedge clk) begin
    if (sram_oe && mem_cs && !mem_rwbar) contention <= contention + 1;
    if (mem_cs && !mem_rwbar && $isunknown(mem_databus)) xz_cycles <= xz_cycles + 1;
    if (mem_cs) cs_cycles <= cs_cycles + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Returns the cycle (1 = first cycle after the accept edge) in which rsp_valid is seen; 0 if none.
  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [ADW-1:0] addr, input logic [31:0] wdata,
                        input logic [1:0] hwe, output int lat);
    @(posedge clk);
    #1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_hwe   = hwe;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_rsp(lat);
  endtask

  task automatic probe_bus(input string name);
    probe_val = 32'h5A5A_C3C3;
    probe_en  = 1'b1;
    #1;
    checks++;
    if (mem_databus !== 32'h5A5A_C3C3) begin
      errors++;
      $display("FAIL %s: databus %h, required %h (bus not released)", name, mem_databus, 32'h5A5A_C3C3);
    end
    probe_en = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({req_ready, rsp_valid, mem_cs, mem_rwbar} !== 4'b1001) begin
      errors++;
      $display("FAIL reset_ctrl: ready/rsp/cs/rwbar %b, required 1001",
               {req_ready, rsp_valid, mem_cs, mem_rwbar});
    end
    checks++;
    if (rsp_rdata !== 32'h0 || mem_adbus !== '0) begin
      errors++;
      $display("FAIL reset_data: rdata %h adbus %h, required 0 and 0", rsp_rdata, mem_adbus);
    end
    probe_bus("reset_bus");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write();
    int lat;
    do_req(1'b1, 5'd5, 32'hDEAD_BEEF, 2'b11, lat);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL write_latency: cycle %0d, required 3", lat); end
    checks++;
    if (sram[10] !== 16'hBEEF || sram[11] !== 16'hDEAD) begin
      errors++;
      $display("FAIL write_sram: [10]=%h [11]=%h, required BEEF DEAD", sram[10], sram[11]);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL write_pulse: rsp_valid %b, required 0", rsp_valid); end
  endtask

  task automatic test_read();
    int lat;
    do_req(1'b0, 5'd5, 32'h0, 2'b11, lat);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL read_latency: cycle %0d, required 4", lat); end
    checks++;
    if (rsp_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL read_data: %h, required DEADBEEF", rsp_rdata);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL read_pulse: rsp_valid %b rdata %h, required 0 DEADBEEF", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_req(1'b0, 5'd5, 32'h0, 2'b11, lat);
    checks++;
    if (lat != 4 || req_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_first: latency %0d ready %b, required 4 1", lat, req_ready);
    end
    // Write accepted in the read's response cycle.
    req_we = 1'b1; req_addr = 5'd7; req_wdata = 32'h1234_5678; req_hwe = 2'b11; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_rsp(lat);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL b2b_write_latency: cycle %0d, required 3", lat); end
    checks++;
    if (rsp_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL b2b_rdata_hold: %h, required DEADBEEF", rsp_rdata);
    end
    req_we = 1'b0; req_addr = 5'd7; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_rsp(lat);
    checks++;
    if (lat != 4 || rsp_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL b2b_read: latency %0d data %h, required 4 12345678", lat, rsp_rdata);
    end
    checks++;
    if (contention != 0 || xz_cycles != 0) begin
      errors++;
      $display("FAIL b2b_bus: contention %0d xz %0d, required 0 0", contention, xz_cycles);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(posedge clk);
    #1;
    req_we = 1'b0; req_addr = 5'd5; req_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (mem_cs !== 1'b1 || mem_adbus !== 6'd11) begin
      errors++; $display("FAIL rdhi_pins: cs %b adbus %0d, required 1 11", mem_cs, mem_adbus);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_cs, mem_rwbar, req_ready, rsp_valid} !== 4'b0110 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL midreset_pins: cs/rwbar/ready/rsp %b rdata %h, required 0110 0",
               {mem_cs, mem_rwbar, req_ready, rsp_valid}, rsp_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid || mem_cs) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midreset_quiet: %0d active cycles, required 0", seen); end
    probe_bus("midreset_bus");
  endtask

  task automatic test_busy_ignore();
    int lat, stray;
    do_req(1'b1, 5'd3, 32'h0BAD_F00D, 2'b11, lat);
    do_req(1'b1, 5'd4, 32'h1111_2222, 2'b11, lat);
    @(posedge clk);
    #1;
    req_we = 1'b0; req_addr = 5'd3; req_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    req_we = 1'b1; req_addr = 5'd4; req_wdata = 32'hFFFF_FFFF;
    lat = 0;
    stray = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_cs && mem_adbus[ADW:1] != 5'd3) stray++;
      if (rsp_valid) begin
        lat = c;
        req_valid = 1'b0;
        break;
      end
      req_addr = req_addr + 5'd1;
    end
    checks++;
    if (lat != 4 || rsp_rdata !== 32'h0BAD_F00D || stray != 0) begin
      errors++;
      $display("FAIL busy_first: latency %0d data %h stray %0d, required 4 0BADF00D 0", lat, rsp_rdata, stray);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (sram[8] !== 16'h2222 || sram[9] !== 16'h1111 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_ignored: [8]=%h [9]=%h ready %b, required 2222 1111 1", sram[8], sram[9], req_ready);
    end
  endtask

  task automatic test_max_addr();
    int lat;
    do_req(1'b1, 5'd31, 32'hCAFE_F00D, 2'b11, lat);
    checks++;
    if (sram[62] !== 16'hF00D || sram[63] !== 16'hCAFE) begin
      errors++; $display("FAIL max_write: [62]=%h [63]=%h, required F00D CAFE", sram[62], sram[63]);
    end
    do_req(1'b0, 5'd31, 32'h0, 2'b11, lat);
    checks++;
    if (lat != 4 || rsp_rdata !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL max_read: latency %0d data %h, required 4 CAFEF00D", lat, rsp_rdata);
    end
  endtask

`ifdef SRAM_CTRL_HWSTRB_EN
  task automatic test_hwstrb();
    int lat, cs_before;
    do_req(1'b1, 5'd10, 32'h0000_0000, 2'b11, lat);
    do_req(1'b1, 5'd10, 32'hAAAA_5555, 2'b10, lat);
    checks++;
    if (lat != 2 || sram[20] !== 16'h0000 || sram[21] !== 16'hAAAA) begin
      errors++;
      $display("FAIL hwe10: latency %0d [20]=%h [21]=%h, required 2 0000 AAAA", lat, sram[20], sram[21]);
    end
    cs_before = cs_cycles;
    do_req(1'b1, 5'd10, 32'hFFFF_FFFF, 2'b00, lat);
    @(negedge clk);
    checks++;
    if (lat != 1 || cs_cycles != cs_before || sram[20] !== 16'h0000 || sram[21] !== 16'hAAAA) begin
      errors++;
      $display("FAIL hwe00: latency %0d cs_cycles %0d [20]=%h [21]=%h, required 1 0 0000 AAAA",
               lat, cs_cycles - cs_before, sram[20], sram[21]);
    end
    do_req(1'b1, 5'd10, 32'h1234_5555, 2'b01, lat);
    checks++;
    if (lat != 2 || sram[20] !== 16'h5555 || sram[21] !== 16'hAAAA) begin
      errors++;
      $display("FAIL hwe01: latency %0d [20]=%h [21]=%h, required 2 5555 AAAA", lat, sram[20], sram[21]);
    end
    do_req(1'b0, 5'd10, 32'h0, 2'b00, lat);
    checks++;
    if (lat != 4 || rsp_rdata !== 32'hAAAA_5555) begin
      errors++; $display("FAIL hwe_read: latency %0d data %h, required 4 AAAA5555", lat, rsp_rdata);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid();
    test_busy_ignore();
    test_max_addr();
`ifdef SRAM_CTRL_HWSTRB_EN
    test_hwstrb();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
